// File: rtl/alu_issue.sv
// Purpose : command FIFO feeding an external registered ALU. Results come back
//           as tagged, in-order responses.
// Latency : a legal op accepted into an empty idle block gives rsp_valid 3 edges
//           after the accept edge. An illegal op gives rsp_valid 1 edge after it.
// Backpr. : cmd_ready drops only when the FIFO is full. A response is held stable
//           until rsp_ready. The next command is dispatched on that same edge.
//
// Ports   : clk/rst_n (async active-low reset)
//           cmd_*     command in: valid/ready, op, a, b, tag
//           alu_*     registered ALU drive (instruction, a, b); alu_l1r is the result
//           rsp_*     response out: valid/ready, data, tag, err
//           busy      FIFO not empty or FSM not idle
// Config  : define ALU_ISSUE_MUL_EN to make opcode 1 (Mul) legal.
//           Without it, Mul returns an error response.
module alu_issue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_op,
    input  logic [63:0]      cmd_a,
    input  logic [63:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [4:0]       alu_instruction,
    output logic [63:0]      alu_a,
    output logic [63:0]      alu_b,
    input  logic [63:0]      alu_l1r,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [4:0]       ALU_NOP  = 5'd31;

    typedef struct packed {
        logic [4:0]       op;
        logic [63:0]      a;
        logic [63:0]      b;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Opcodes the ALU may be driven with; everything else becomes an error response.
    function automatic logic op_legal(input logic [4:0] op);
        logic ok;
        case (op)
            5'd0, 5'd2, 5'd3, 5'd4: ok = 1'b1;
`ifdef ALU_ISSUE_MUL_EN
            5'd1:                   ok = 1'b1;
`else
            5'd1:                   ok = 1'b0;
`endif
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ---------------------------------------------------------------- FIFO
    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    cmd_t             head;
    logic             push, pop;

    state_t           state_q;

    assign head      = mem_q[rd_ptr_q];
    assign cmd_ready = (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    // The FSM takes the head when idle, or on the edge its response is accepted.
    assign pop       = (count_q != '0) &&
                       ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------------- FSM
    logic [4:0]       alu_op_q;
    logic [63:0]      alu_a_q, alu_b_q;
    logic             rsp_valid_q, rsp_err_q;
    logic [63:0]      rsp_data_q;
    logic [TAG_W-1:0] rsp_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_op_q    <= ALU_NOP;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // The ALU bus carries a real operation only during ISSUE.
            alu_op_q <= ALU_NOP;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            case (state_q)
                IDLE, RESP: begin
                    if (pop) begin
                        rsp_tag_q <= head.tag;
                        if (op_legal(head.op)) begin
                            alu_op_q    <= head.op;
                            alu_a_q     <= head.a;
                            alu_b_q     <= head.b;
                            rsp_valid_q <= 1'b0;
                            state_q     <= ISSUE;
                        end else begin
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end else if ((state_q == IDLE) || rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_data_q  <= alu_l1r;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_instruction = alu_op_q;
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_tag         = rsp_tag_q;
    assign rsp_err         = rsp_err_q;
    assign busy            = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue.sv
// Purpose : self-checking bench for alu_issue, using a scoreboard and a reference model.
// Latency : n/a (bench).
// Backpr. : rsp_ready is driven by directed phases and by a random phase.
module tb_alu_issue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [4:0]       cmd_op;
    logic [63:0]      cmd_a, cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [4:0]       alu_instruction;
    logic [63:0]      alu_a, alu_b;
    logic [63:0]      alu_l1r;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             busy;

    alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_a           (cmd_a),
        .cmd_b           (cmd_b),
        .cmd_tag         (cmd_tag),
        .alu_instruction (alu_instruction),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_l1r         (alu_l1r),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_tag         (rsp_tag),
        .rsp_err         (rsp_err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------ reference models
`ifdef ALU_ISSUE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    function automatic bit is_legal(input logic [4:0] op);
        return (op <= 5'd4) && (op != 5'd1 || MUL_EN);
    endfunction

    // Expected response for a command: {err, data}.
    function automatic logic [64:0] expect_rsp(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        if (!is_legal(op)) return {1'b1, 64'd0};
        case (op)
            5'd0:    return {1'b0, a + b};
            5'd1:    return {1'b0, a * b};
            5'd2:    return {1'b0, a | b};
            5'd3:    return {1'b0, a ^ b};
            default: return {1'b0, a & b};
        endcase
    endfunction

    // External registered ALU: the result appears one edge after the inputs are sampled.
    always @(posedge clk) begin
        case (alu_instruction)
            5'd0:    alu_l1r <= alu_a + alu_b;
            5'd1:    alu_l1r <= alu_a * alu_b;
            5'd2:    alu_l1r <= alu_a | alu_b;
            5'd3:    alu_l1r <= alu_a ^ alu_b;
            5'd4:    alu_l1r <= alu_a & alu_b;
            default: alu_l1r <= 64'd0;
        endcase
    end

    // ------------------------------------------------ scoreboard
    typedef struct {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    logic             prev_stall = 1'b0;
    logic [63:0]      prev_data;
    logic [TAG_W-1:0] prev_tag;
    logic             prev_err;

    // Monitor: samples on the falling edge, midway between active edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && rsp_valid)
                chk("rsp_hold", 64'({rsp_err, rsp_tag, rsp_data[31:0]}),
                                64'({prev_err, prev_tag, prev_data[31:0]}));
            // The ALU bus is either the idle pattern or a legal operation.
            if (alu_instruction == 5'd31)
                chk("alu_idle_bus", alu_a | alu_b, 64'd0);
            else
                chk("alu_legal_op", 64'(is_legal(alu_instruction)), 64'd1);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            prev_tag   = rsp_tag;
            prev_err   = rsp_err;
        end
    end

    // ------------------------------------------------ driver tasks
    // Offers one command and returns once it is accepted. The expected response
    // is pushed to the scoreboard on the accept edge.
    task automatic send(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] tag, output int waited);
        logic     rdy;
        exp_t     e;
        logic [64:0] m;
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        forever begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) begin
                m      = expect_rsp(op, a, b);
                e.data = m[63:0];
                e.err  = m[64];
                e.tag  = tag;
                exp_q.push_back(e);
                break;
            end
            waited++;
            if (waited > 200) begin
                chk("cmd_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        #1 cmd_valid = 1'b0;
    endtask

    // Counts active edges from the accept edge until rsp_valid is seen.
    task automatic wait_rsp(input bit nop_bus, output int edges);
        edges = 0;
        forever begin
            @(negedge clk);
            if (nop_bus) chk("alu_stays_31", 64'(alu_instruction), 64'd31);
            if (rsp_valid) break;
            if (edges >= 50) begin
                chk("rsp_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_alu_instr", 64'(alu_instruction), 64'd31);
        chk("rst_alu_ab", alu_a | alu_b, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    // ------------------------------------------------ stimulus
    bit rand_phase = 1'b0;

    initial begin
        int w, edges;
        logic [64:0] m;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b0;
        #23;
        chk_reset_state();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Add 5+7 tag 3: response 3 edges after accept.
        rsp_ready = 1'b1;
        send(5'd0, 64'd5, 64'd7, 4'd3, w);
        wait_rsp(1'b0, edges);
        chk("add_latency", 64'(edges), 64'd3);
        chk("add_data", rsp_data, 64'd12);
        chk("add_tag", 64'(rsp_tag), 64'd3);
        chk("add_err", 64'(rsp_err), 64'd0);
        drain();

        // Illegal opcode 9: error response 1 edge after accept, ALU never driven.
        send(5'd9, 64'hdead, 64'hbeef, 4'd1, w);
        wait_rsp(1'b1, edges);
        chk("ill_latency", 64'(edges), 64'd1);
        chk("ill_data", rsp_data, 64'd0);
        chk("ill_err", 64'(rsp_err), 64'd1);
        chk("ill_tag", 64'(rsp_tag), 64'd1);
        drain();

        // Mul 6*7: legal only when the multiply option is built in.
        send(5'd1, 64'd6, 64'd7, 4'd5, w);
        wait_rsp(!MUL_EN, edges);
        chk("mul_latency", 64'(edges), MUL_EN ? 64'd3 : 64'd1);
        chk("mul_data", rsp_data, MUL_EN ? 64'd42 : 64'd0);
        chk("mul_err", 64'(rsp_err), MUL_EN ? 64'd0 : 64'd1);
        drain();

        // Fill with rsp_ready low: one command sits in the FSM, DEPTH wait in the FIFO.
        rsp_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            send(5'(i % 5 == 1 ? 0 : i % 5), 64'(i * 100 + 1), 64'(i + 3), 4'(8 + i), w);
            chk("fill_no_wait", 64'(w), 64'd0);
        end
        @(negedge clk);
        chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        fork
            send(5'd3, 64'h55, 64'hff, 4'd13, w);
            begin
                repeat (6) @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        chk("held_cmd_waited", 64'(w >= 6), 64'd1);
        drain();

        // Randomized traffic with random consumer backpressure.
        rand_phase = 1'b1;
        fork
            while (rand_phase) begin
                @(posedge clk);
                #1 rsp_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int i = 0; i < 150; i++) begin
            logic [4:0]  op;
            logic [63:0] a, b;
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(5, 31)) : 5'($urandom_range(0, 4));
            a  = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            b  = {$urandom, $urandom};
            send(op, a, b, 4'($urandom), w);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_phase = 1'b0;
        @(posedge clk);
        #2 rsp_ready = 1'b1;
        drain();

        // Reset while in CAPTURE with two commands queued.
        rsp_ready = 1'b0;
        send(5'd0, 64'd1, 64'd2, 4'd6, w);
        send(5'd2, 64'd3, 64'd4, 4'd7, w);
        send(5'd4, 64'd5, 64'd6, 4'd2, w);
        rst_n = 1'b0;
        exp_q.delete();
        #2;
        chk_reset_state();
        @(negedge clk) rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_quiet",
                64'({rsp_valid, busy, cmd_ready, alu_instruction}),
                64'({1'b0, 1'b0, 1'b1, 5'd31}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
